// File: rtl/s3g_requester.sv
// Host-side S3G link initiator: frames a request (0xD5, len, payload, CRC8) over a UART
// byte interface, then receives and CRC-checks the response, with internal timeout and retry.
module s3g_requester #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [7:0]   req_len,
    input  logic [127:0] req_payload,
    output logic [7:0]   tx_data,
    output logic         tx_wr,
    input  logic         tx_done,
    input  logic [7:0]   rx_data,
    input  logic         rx_done,
    output logic         resp_valid,
    output logic [7:0]   resp_len,
    output logic [127:0] resp_payload,
    output logic         resp_error,
    output logic [1:0]   err_code
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [3:0] {
        IDLE, TX_D5, TX_LEN, TX_PAY, TX_CRC, RX_D5, RX_LEN, RX_PAY, RX_CRC, RETRY
    } state_t;

    // Maxim/iButton CRC8 (reflected 0x8C), one byte
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    state_t            state_r, state_s;
    logic              tx_wait_r, tx_wait_s;
    logic [4:0]        idx_r, idx_s;
    logic [7:0]        crc_r, crc_s;
    logic [4:0]        req_len_r, req_len_s;
    logic [127:0]      req_pay_r, req_pay_s;
    logic [4:0]        rx_len_r, rx_len_s;
    logic [127:0]      rx_pay_r, rx_pay_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
    logic [RW-1:0]     retry_r, retry_s;
    logic              req_ready_r, req_ready_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              tx_wr_r, tx_wr_s;
    logic              resp_valid_r, resp_valid_s;
    logic [7:0]        resp_len_r, resp_len_s;
    logic [127:0]      resp_payload_r, resp_payload_s;
    logic              resp_error_r, resp_error_s;
    logic [1:0]        err_code_r, err_code_s;
    logic [7:0]        tx_byte_s, req_byte_s;
    logic              tx_state_s, rx_state_s, sent_s, timeout_s, fail_s;
    logic [1:0]        cause_s;

    assign req_ready    = req_ready_r;
    assign tx_data      = tx_data_r;
    assign tx_wr        = tx_wr_r;
    assign resp_valid   = resp_valid_r;
    assign resp_len     = resp_len_r;
    assign resp_payload = resp_payload_r;
    assign resp_error   = resp_error_r;
    assign err_code     = err_code_r;

    // Next-state and next-output computation for the whole requester
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        crc_s          = crc_r;
        req_len_s      = req_len_r;
        req_pay_s      = req_pay_r;
        rx_len_s       = rx_len_r;
        rx_pay_s       = rx_pay_r;
        retry_s        = retry_r;
        tx_wait_s      = 1'b0;
        tx_wr_s        = 1'b0;
        tx_data_s      = tx_data_r;
        resp_valid_s   = 1'b0;
        resp_len_s     = resp_len_r;
        resp_payload_s = resp_payload_r;
        resp_error_s   = 1'b0;
        err_code_s     = err_code_r;
        tx_byte_s      = 8'h00;
        fail_s         = 1'b0;
        cause_s        = 2'd0;
        req_byte_s     = req_pay_r[{idx_r[3:0], 3'b000} +: 8];
        tx_state_s     = (state_r == TX_D5) || (state_r == TX_LEN) ||
                         (state_r == TX_PAY) || (state_r == TX_CRC);
        rx_state_s     = (state_r == RX_D5) || (state_r == RX_LEN) ||
                         (state_r == RX_PAY) || (state_r == RX_CRC);
        sent_s         = tx_wait_r && tx_done;
        timeout_s      = rx_state_s && !rx_done && (to_cnt_r == TO_LAST);

        // Idle gap counter restarts on every received byte
        if (rx_state_s && !rx_done) begin
            to_cnt_s = to_cnt_r + 1'b1;
        end else begin
            to_cnt_s = '0;
        end

        case (state_r)
            IDLE: begin
                if (req_valid && ((req_len == 8'd0) || (req_len > 8'd16))) begin
                    resp_error_s = 1'b1;
                    err_code_s   = 2'd3;
                end else if (req_valid) begin
                    req_len_s = req_len[4:0];
                    req_pay_s = req_payload;
                    idx_s     = 5'd0;
                    crc_s     = 8'h00;
                    retry_s   = '0;
                    state_s   = TX_D5;
                end else begin
                    state_s = IDLE;
                end
            end
            TX_D5: begin
                tx_byte_s = 8'hD5;
                state_s   = sent_s ? TX_LEN : TX_D5;
            end
            TX_LEN: begin
                tx_byte_s = {3'b000, req_len_r};
                idx_s     = 5'd0;
                state_s   = sent_s ? TX_PAY : TX_LEN;
            end
            TX_PAY: begin
                tx_byte_s = req_byte_s;
                if (!tx_wait_r) begin
                    crc_s = crc8_byte(crc_r, req_byte_s);
                end else if (sent_s && (idx_r + 5'd1 == req_len_r)) begin
                    idx_s   = 5'd0;
                    state_s = TX_CRC;
                end else if (sent_s) begin
                    idx_s = idx_r + 5'd1;
                end else begin
                    state_s = TX_PAY;
                end
            end
            TX_CRC: begin
                tx_byte_s = crc_r;
                if (sent_s) begin
                    crc_s   = 8'h00;
                    state_s = RX_D5;
                end else begin
                    state_s = TX_CRC;
                end
            end
            RX_D5: begin
                if (timeout_s) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd1;
                end else if (rx_done && (rx_data == 8'hD5)) begin
                    state_s = RX_LEN;
                end else begin
                    state_s = RX_D5;
                end
            end
            RX_LEN: begin
                if (timeout_s) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd1;
                end else if (rx_done && (rx_data > 8'd16)) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd3;
                end else if (rx_done) begin
                    rx_len_s = rx_data[4:0];
                    rx_pay_s = '0;
                    idx_s    = 5'd0;
                    state_s  = (rx_data == 8'd0) ? RX_CRC : RX_PAY;
                end else begin
                    state_s = RX_LEN;
                end
            end
            RX_PAY: begin
                if (timeout_s) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd1;
                end else if (rx_done) begin
                    rx_pay_s[{idx_r[3:0], 3'b000} +: 8] = rx_data;
                    crc_s   = crc8_byte(crc_r, rx_data);
                    idx_s   = (idx_r + 5'd1 == rx_len_r) ? 5'd0 : idx_r + 5'd1;
                    state_s = (idx_r + 5'd1 == rx_len_r) ? RX_CRC : RX_PAY;
                end else begin
                    state_s = RX_PAY;
                end
            end
            RX_CRC: begin
                if (timeout_s) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd1;
                end else if (rx_done && (rx_data == crc_r)) begin
                    resp_valid_s   = 1'b1;
                    resp_len_s     = {3'b000, rx_len_r};
                    resp_payload_s = rx_pay_r;
                    retry_s        = '0;
                    state_s        = IDLE;
                end else if (rx_done) begin
                    fail_s  = 1'b1;
                    cause_s = 2'd2;
                end else begin
                    state_s = RX_CRC;
                end
            end
            RETRY: begin
                if (retry_r < RETRY_MAX) begin
                    retry_s = retry_r + 1'b1;
                    idx_s   = 5'd0;
                    crc_s   = 8'h00;
                    state_s = TX_D5;
                end else begin
                    resp_error_s = 1'b1;
                    retry_s      = '0;
                    state_s      = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        state_s    = fail_s ? RETRY : state_s;
        err_code_s = fail_s ? cause_s : err_code_s;

        // One write strobe per byte, then hold until the transmitter reports completion
        if (tx_state_s && !tx_wait_r) begin
            tx_wr_s   = 1'b1;
            tx_data_s = tx_byte_s;
            tx_wait_s = 1'b1;
        end else if (tx_state_s) begin
            tx_wait_s = !tx_done;
        end else begin
            tx_wait_s = 1'b0;
        end

        req_ready_s = (state_s == IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            tx_wait_r      <= 1'b0;
            idx_r          <= 5'd0;
            crc_r          <= 8'h00;
            req_len_r      <= 5'd0;
            req_pay_r      <= 128'd0;
            rx_len_r       <= 5'd0;
            rx_pay_r       <= 128'd0;
            to_cnt_r       <= '0;
            retry_r        <= '0;
            req_ready_r    <= 1'b1;
            tx_data_r      <= 8'h00;
            tx_wr_r        <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_len_r     <= 8'd0;
            resp_payload_r <= 128'd0;
            resp_error_r   <= 1'b0;
            err_code_r     <= 2'd0;
        end else begin
            state_r        <= state_s;
            tx_wait_r      <= tx_wait_s;
            idx_r          <= idx_s;
            crc_r          <= crc_s;
            req_len_r      <= req_len_s;
            req_pay_r      <= req_pay_s;
            rx_len_r       <= rx_len_s;
            rx_pay_r       <= rx_pay_s;
            to_cnt_r       <= to_cnt_s;
            retry_r        <= retry_s;
            req_ready_r    <= req_ready_s;
            tx_data_r      <= tx_data_s;
            tx_wr_r        <= tx_wr_s;
            resp_valid_r   <= resp_valid_s;
            resp_len_r     <= resp_len_s;
            resp_payload_r <= resp_payload_s;
            resp_error_r   <= resp_error_s;
            err_code_r     <= err_code_s;
        end
    end
endmodule
